// File: rtl/prga.sv
// RC4 pseudo-random generation stage.
// Reads the S array left by the key schedule, swaps entries in place and
// decrypts a length-prefixed message from ciphertext memory into plaintext
// memory. All three memories are synchronous-read 256x8.
//
// Every output is registered. The combinational block works out the value
// that each output must hold in the *next* state and registers it. The
// outputs therefore change together with the state register, and an
// asynchronous reset clears them immediately.
// Read data is consumed in each wait state (I_W, J_W, P_W, LEN_W). At that
// point it is already valid, because the address was presented in the
// preceding cycle and is held.
module prga (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LEN_A = 4'd1,
    ST_LEN_W = 4'd2,
    ST_LEN_S = 4'd3,
    ST_I_A   = 4'd4,
    ST_I_W   = 4'd5,
    ST_J_A   = 4'd6,
    ST_J_W   = 4'd7,
    ST_SWP1  = 4'd8,
    ST_SWP2  = 4'd9,
    ST_P_A   = 4'd10,
    ST_P_W   = 4'd11,
    ST_OUT   = 4'd12
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;

  // Algorithm registers
  logic [7:0] r_i,   w_i;
  logic [7:0] r_j,   w_j;
  logic [7:0] r_k,   w_k;
  logic [7:0] r_len, w_len;
  logic [7:0] r_si,  w_si;
  logic [7:0] r_sj,  w_sj;

  // Output registers
  logic       r_rdy,       w_rdy;
  logic [7:0] r_s_addr,    w_s_addr;
  logic [7:0] r_s_wrdata,  w_s_wrdata;
  logic       r_s_wren,    w_s_wren;
  logic [7:0] r_ct_addr,   w_ct_addr;
  logic [7:0] r_pt_addr,   w_pt_addr;
  logic [7:0] r_pt_wrdata, w_pt_wrdata;
  logic       r_pt_wren,   w_pt_wren;

  // Next-state logic and next values for the datapath and outputs; write enables default to idle
  always_comb begin
    w_state_nxt = r_state;
    w_i         = r_i;
    w_j         = r_j;
    w_k         = r_k;
    w_len       = r_len;
    w_si        = r_si;
    w_sj        = r_sj;
    w_s_addr    = r_s_addr;
    w_s_wrdata  = r_s_wrdata;
    w_s_wren    = 1'b0;
    w_ct_addr   = r_ct_addr;
    w_pt_addr   = r_pt_addr;
    w_pt_wrdata = r_pt_wrdata;
    w_pt_wren   = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nxt = ST_LEN_A;
          w_i         = 8'd0;
          w_j         = 8'd0;
          w_k         = 8'd1;
          w_ct_addr   = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LEN_A: w_state_nxt = ST_LEN_W;
      ST_LEN_W: begin
        // ct[0] is valid now; capture the length and write it as pt[0] in LEN_S
        w_state_nxt = ST_LEN_S;
        w_len       = ct_rddata;
        w_pt_addr   = 8'd0;
        w_pt_wrdata = ct_rddata;
        w_pt_wren   = 1'b1;
      end
      ST_LEN_S: begin
        if (r_len == 8'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_I_A;
          w_i         = r_i + 8'd1;
          w_s_addr    = r_i + 8'd1;
        end
      end
      ST_I_A: w_state_nxt = ST_I_W;
      ST_I_W: begin
        // S[i] is valid now; form j and address S[j]
        w_state_nxt = ST_J_A;
        w_si        = s_rddata;
        w_j         = r_j + s_rddata;
        w_s_addr    = r_j + s_rddata;
      end
      ST_J_A: w_state_nxt = ST_J_W;
      ST_J_W: begin
        // S[j] is valid now; first swap write puts it at S[i]
        w_state_nxt = ST_SWP1;
        w_sj        = s_rddata;
        w_s_addr    = r_i;
        w_s_wrdata  = s_rddata;
        w_s_wren    = 1'b1;
      end
      ST_SWP1: begin
        w_state_nxt = ST_SWP2;
        w_s_addr    = r_j;
        w_s_wrdata  = r_si;
        w_s_wren    = 1'b1;
      end
      ST_SWP2: begin
        w_state_nxt = ST_P_A;
        w_s_addr    = r_si + r_sj;
        w_ct_addr   = r_k;
      end
      ST_P_A: w_state_nxt = ST_P_W;
      ST_P_W: begin
        // pad byte and ciphertext byte are both valid now
        w_state_nxt = ST_OUT;
        w_pt_addr   = r_k;
        w_pt_wrdata = s_rddata ^ ct_rddata;
        w_pt_wren   = 1'b1;
      end
      ST_OUT: begin
        w_k = r_k + 8'd1;
        if (r_k == r_len) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_I_A;
          w_i         = r_i + 8'd1;
          w_s_addr    = r_i + 8'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    w_rdy = (w_state_nxt == ST_IDLE);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i         <= 8'd0;
      r_j         <= 8'd0;
      r_k         <= 8'd0;
      r_len       <= 8'd0;
      r_si        <= 8'd0;
      r_sj        <= 8'd0;
      r_rdy       <= 1'b1;
      r_s_addr    <= 8'd0;
      r_s_wrdata  <= 8'd0;
      r_s_wren    <= 1'b0;
      r_ct_addr   <= 8'd0;
      r_pt_addr   <= 8'd0;
      r_pt_wrdata <= 8'd0;
      r_pt_wren   <= 1'b0;
    end else begin
      r_i         <= w_i;
      r_j         <= w_j;
      r_k         <= w_k;
      r_len       <= w_len;
      r_si        <= w_si;
      r_sj        <= w_sj;
      r_rdy       <= w_rdy;
      r_s_addr    <= w_s_addr;
      r_s_wrdata  <= w_s_wrdata;
      r_s_wren    <= w_s_wren;
      r_ct_addr   <= w_ct_addr;
      r_pt_addr   <= w_pt_addr;
      r_pt_wrdata <= w_pt_wrdata;
      r_pt_wren   <= w_pt_wren;
    end
  end

  assign rdy       = r_rdy;
  assign s_addr    = r_s_addr;
  assign s_wrdata  = r_s_wrdata;
  assign s_wren    = r_s_wren;
  assign ct_addr   = r_ct_addr;
  assign pt_addr   = r_pt_addr;
  assign pt_wrdata = r_pt_wrdata;
  assign pt_wren   = r_pt_wren;

endmodule

// File: tb/tb_prga.sv
// Directed testbench for prga with behavioural S, CT and PT memories.
module tb_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic [7:0] ld_buf [256];
  logic [1:0] ld_sel;
  logic [7:0] ld_addr, ld_data;

  int s_wr_cnt = 0;
  int n_tests  = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
  );

  // S memory: synchronous read, bench loader has priority over the DUT
  always @(posedge clk) begin
    if (ld_sel == 2'd1) s_mem[ld_addr] <= ld_data;
    else if (s_wren)    s_mem[s_addr]  <= s_wrdata;
    s_rddata <= s_mem[s_addr];
  end

  // Ciphertext memory: synchronous read, loaded by the bench
  always @(posedge clk) begin
    if (ld_sel == 2'd2) ct_mem[ld_addr] <= ld_data;
    ct_rddata <= ct_mem[ct_addr];
  end

  // Plaintext memory: written by the DUT, pre-filled by the bench
  always @(posedge clk) begin
    if (ld_sel == 2'd3) pt_mem[ld_addr] <= ld_data;
    else if (pt_wren)   pt_mem[pt_addr] <= pt_wrdata;
  end

  // Count S writes issued by the DUT
  always @(posedge clk) begin
    if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load_mem(input logic [1:0] sel);
    for (int a = 0; a < 256; a++) begin
      @(negedge clk);
      ld_sel  = sel;
      ld_addr = a[7:0];
      ld_data = ld_buf[a];
    end
    @(negedge clk);
    ld_sel = 2'd0;
  endtask

  task automatic load_identity_s();
    for (int a = 0; a < 256; a++) ld_buf[a] = a[7:0];
    load_mem(2'd1);
  endtask

  task automatic prefill_pt();
    for (int a = 0; a < 256; a++) ld_buf[a] = 8'hEE;
    load_mem(2'd3);
  endtask

  task automatic load_short_ct(input logic [7:0] len, input logic [7:0] b1, input logic [7:0] b2);
    for (int a = 0; a < 256; a++) ld_buf[a] = 8'h00;
    ld_buf[0] = len;
    ld_buf[1] = b1;
    ld_buf[2] = b2;
    load_mem(2'd2);
  endtask

  // Start one run with a single-cycle en and count the cycles with rdy low
  task automatic run_msg(input bit pulse_in_out1, output int cycles);
    bit done;
    done = 1'b0;
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    cycles = 1;
    for (int c = 0; c < 5000 && !done; c++) begin
      @(negedge clk);
      en = pulse_in_out1 && (cycles == 11);
      if (rdy) done = 1'b1;
      else     cycles++;
    end
    en = 1'b0;
    check_eq("run_done", {31'd0, done}, 32'd1);
  endtask

  logic [7:0] key [3];
  logic [7:0] sm  [256];
  logic [7:0] exp_pt [256];

  initial begin
    int         cyc;
    int         w0;
    logic [7:0] ki, kj, t;

    rst_n   = 1'b0;
    en      = 1'b0;
    ld_sel  = 2'd0;
    ld_addr = 8'd0;
    ld_data = 8'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_rdy",     {31'd0, rdy},     32'd1);
    check_eq("rst_s_wren",  {31'd0, s_wren},  32'd0);
    check_eq("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    check_eq("rst_s_addr",  {24'd0, s_addr},  32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_rdy",     {31'd0, rdy},     32'd1);
    check_eq("post_rst_ct_addr", {24'd0, ct_addr}, 32'd0);
    check_eq("post_rst_pt_addr", {24'd0, pt_addr}, 32'd0);

    // Zero-length message
    load_identity_s();
    prefill_pt();
    load_short_ct(8'd0, 8'h41, 8'h00);
    w0 = s_wr_cnt;
    run_msg(1'b0, cyc);
    check_eq("l0_cycles", cyc, 32'd3);
    check_eq("l0_pt0",    {24'd0, pt_mem[0]}, 32'h00);
    check_eq("l0_pt1",    {24'd0, pt_mem[1]}, 32'hEE);
    check_eq("l0_s_wr",   s_wr_cnt - w0, 32'd0);

    // Two-byte message on identity S
    load_short_ct(8'd2, 8'h41, 8'h00);
    w0 = s_wr_cnt;
    run_msg(1'b0, cyc);
    check_eq("l2_cycles", cyc, 32'd21);
    check_eq("l2_pt0", {24'd0, pt_mem[0]}, 32'h02);
    check_eq("l2_pt1", {24'd0, pt_mem[1]}, 32'h43);
    check_eq("l2_pt2", {24'd0, pt_mem[2]}, 32'h05);
    check_eq("l2_s1",  {24'd0, s_mem[1]},  32'h01);
    check_eq("l2_s2",  {24'd0, s_mem[2]},  32'h03);
    check_eq("l2_s3",  {24'd0, s_mem[3]},  32'h02);
    check_eq("l2_s_wr", s_wr_cnt - w0, 32'd4);

    // en pulsed during OUT of byte 1 is ignored
    load_identity_s();
    prefill_pt();
    run_msg(1'b1, cyc);
    check_eq("busy_en_cycles", cyc, 32'd21);
    check_eq("busy_en_pt1", {24'd0, pt_mem[1]}, 32'h43);
    check_eq("busy_en_pt2", {24'd0, pt_mem[2]}, 32'h05);
    repeat (2) @(negedge clk);
    check_eq("busy_en_idle", {31'd0, rdy}, 32'd1);

    // Asynchronous reset during SWP1 of byte 1
    load_identity_s();
    prefill_pt();
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (7) @(negedge clk);
    check_eq("swp1_wren", {31'd0, s_wren}, 32'd1);
    w0 = s_wr_cnt;
    rst_n = 1'b0;
    #1;
    check_eq("arst_s_wren",   {31'd0, s_wren},   32'd0);
    check_eq("arst_rdy",      {31'd0, rdy},      32'd1);
    check_eq("arst_s_addr",   {24'd0, s_addr},   32'd0);
    check_eq("arst_s_wrdata", {24'd0, s_wrdata}, 32'd0);
    check_eq("arst_pt_wren",  {31'd0, pt_wren},  32'd0);
    repeat (3) @(negedge clk);
    check_eq("arst_no_wr", s_wr_cnt - w0, 32'd0);
    rst_n = 1'b1;
    load_identity_s();
    prefill_pt();
    run_msg(1'b0, cyc);
    check_eq("rerun_cycles", cyc, 32'd21);
    check_eq("rerun_pt1", {24'd0, pt_mem[1]}, 32'h43);
    check_eq("rerun_pt2", {24'd0, pt_mem[2]}, 32'h05);

    // Full-length message against a software RC4 (key 00 03 3C)
    key[0] = 8'h00;
    key[1] = 8'h03;
    key[2] = 8'h3C;
    for (int a = 0; a < 256; a++) sm[a] = a[7:0];
    kj = 8'd0;
    for (int a = 0; a < 256; a++) begin
      kj     = kj + sm[a] + key[a % 3];
      t      = sm[a];
      sm[a]  = sm[kj];
      sm[kj] = t;
    end
    for (int a = 0; a < 256; a++) ld_buf[a] = sm[a];
    load_mem(2'd1);
    ld_buf[0] = 8'd255;
    for (int a = 1; a < 256; a++) ld_buf[a] = 8'(a * 37 + 11);
    load_mem(2'd2);
    ki = 8'd0;
    kj = 8'd0;
    for (int k = 1; k < 256; k++) begin
      ki        = ki + 8'd1;
      kj        = kj + sm[ki];
      t         = sm[ki];
      sm[ki]    = sm[kj];
      sm[kj]    = t;
      t         = sm[ki] + sm[kj];
      exp_pt[k] = sm[t] ^ 8'(k * 37 + 11);
    end
    prefill_pt();
    run_msg(1'b0, cyc);
    check_eq("l255_cycles", cyc, 32'd2298);
    check_eq("l255_pt0", {24'd0, pt_mem[0]}, 32'd255);
    for (int k = 1; k < 256; k++) begin
      check_eq($sformatf("l255_pt%0d", k), {24'd0, pt_mem[k]}, {24'd0, exp_pt[k]});
    end
    for (int a = 0; a < 256; a++) begin
      check_eq($sformatf("l255_s%0d", a), {24'd0, s_mem[a]}, {24'd0, sm[a]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prga.md
PRGA -- requirements
Module: prga

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 en  input  1  start request; sampled only while rdy=1.
REQ-004 rdy  output  1  high = idle and able to accept en.
REQ-005 s_addr  output  8  S-memory address.
REQ-006 s_rddata  input  8  S-memory read data.
REQ-007 s_wrdata  output  8  S-memory write data.
REQ-008 s_wren  output  1  S-memory write enable.
REQ-009 ct_addr  output  8  ciphertext-memory read address.
REQ-010 ct_rddata  input  8  ciphertext read data.
REQ-011 pt_addr  output  8  plaintext-memory address.
REQ-012 pt_wrdata  output  8  plaintext write data.
REQ-013 pt_wren  output  1  plaintext write enable.

Function
REQ-014 Block SHALL be the reader of the S array produced by the key-schedule block: it reads S, performs the RC4 PRGA, swaps S entries in place and writes decrypted bytes.
REQ-015 Memories SHALL be synchronous single-port 256x8: rddata is valid one cycle after the address; a write occurs on the edge where wren=1.
REQ-016 The message SHALL be length-prefixed: ct[0]=L (0..255), ct[1..L]=ciphertext; the output SHALL be pt[0]=L, pt[1..L]=plaintext.
REQ-017 Algorithm: i=j=0; for k=1..L: i=i+1; j=j+S[i]; swap S[i],S[j]; pt[k]=S[(S[i]+S[j])]^ct[k]. All sums SHALL be mod 256 (8-bit wrap, carry discarded).
REQ-018 States, one cycle each: IDLE, LEN_A, LEN_W, LEN_S, I_A, I_W, J_A, J_W, SWP1, SWP2, P_A, P_W, OUT.
REQ-019 IDLE: rdy=1; en=1 -> LEN_A, with i=j=0 and k=1; otherwise stay in IDLE.
REQ-020 LEN_A drives ct_addr=0. LEN_W waits. LEN_S latches L=ct_rddata and writes pt[0]=L; L=0 -> IDLE, else -> I_A.
REQ-021 I_A: s_addr=i+1, i<=i+1. I_W: wait. J_A: si<=s_rddata, j<=j+s_rddata, s_addr=j+s_rddata. J_W: wait.
REQ-022 SWP1: sj<=s_rddata; write S[i]=s_rddata. SWP2: write S[j]=si.
REQ-023 P_A: s_addr=si+sj, ct_addr=k. P_W: wait. OUT: write pt[k]=s_rddata^ct_rddata, k<=k+1; k=L -> IDLE, else -> I_A.
REQ-024 rdy SHALL be low from the cycle after en is accepted until return to IDLE: exactly 3+9*L cycles.
REQ-025 i=j (incl. i=j after wrap) SHALL give both swap writes to the same address with an unchanged value; no special-casing.
REQ-026 en while busy SHALL be ignored; en held high in IDLE at completion SHALL start a new run (S not reinitialised).
REQ-027 s_wren and pt_wren SHALL be high only in SWP1/SWP2 and LEN_S/OUT respectively. At most one write per memory per cycle.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, rdy=1, s_wren=pt_wren=0, all addresses/data 0, i=j=0, k=0, L=0, regardless of current state.
REQ-029 Reset mid-run SHALL abandon the run; memory contents already written are not restored.

Verification
REQ-030 Reset pulse, then check: rdy=1, s_wren=0, pt_wren=0, s_addr=0.
REQ-031 S=identity, ct[0]=0, en for 1 cycle -> pt[0]=0, rdy back to 1 after 3 cycles, no S writes.
REQ-032 S=identity, ct={2,0x41,0x00}: pt[1]=0x43 (pad 2), pt[2]=0x05 (pad S[5]=5); S[2]=3, S[3]=2; rdy low exactly 21 cycles.
REQ-033 L=255 against a golden software RC4 model using the key-schedule output for key 0x00033C: all 255 pt bytes match; rdy high after 2298 cycles.
REQ-034 Pulse en during OUT of byte 1 -> ignored; the run completes normally.
REQ-035 Assert rst_n=0 during SWP1 -> outputs reset in the same cycle (asynchronous), no further writes; a new en then runs correctly.
